// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide controller:
// operand width, op_code values and controller state encoding.
package hilo_muldiv_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Two's-complement magnitude for signed ops; 0x80000000 maps to 2^31 unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative datapath: shift-add multiply or restoring shift-subtract
// divide on unsigned magnitudes, one step per enabled cycle.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  input  logic              step,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quot,
  output logic [XLEN-1:0]   rem
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic              div_q;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   diff;
  logic              ge;

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge      = (shifted >= {1'b0, opnd_q});
    diff    = shifted[XLEN-1:0] - opnd_q;
    acc_d   = acc_q;
    if (start) begin
      acc_d = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
    end else if (step) begin
      if (div_q) acc_d = {(ge ? diff : shifted[XLEN-1:0]), acc_q[XLEN-2:0], ge};
      else       acc_d = {add_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (start) begin
        opnd_q <= is_div ? mag_b : mag_a;
        div_q  <= is_div;
      end
    end
  end

  assign prod = acc_q;
  assign quot = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO controller: accepts mul/div/MTHI/MTLO, sequences the iterative
// datapath, applies sign fixup and owns the HI/LO registers and stall.
module hilo_muldiv_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  input  logic            hilo_rd,
  output logic            op_ready,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            div0,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  import hilo_muldiv_ctrl_pkg::*;

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              done_q, div0_q, pneg_q, rneg_q, isdiv_q;

  logic              accept, is_md, is_div_op, sgn_op, b_zero, start_md;
  logic [XLEN-1:0]   mag_a, mag_b, quot, rem, quot_fix, rem_fix;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    accept    = op_valid && (state_q == ST_IDLE) && (op_code <= OP_MTLO);
    is_md     = ~op_code[2];
    is_div_op = op_code[1];
    sgn_op    = ~op_code[0];
    b_zero    = (op_b == '0);
    start_md  = accept && is_md && !(is_div_op && b_zero);
    mag_a     = mag(op_a, sgn_op);
    mag_b     = mag(op_b, sgn_op);
    prod_fix  = pneg_q ? -prod : prod;
    quot_fix  = pneg_q ? -quot : quot;
    rem_fix   = rneg_q ? -rem  : rem;
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_md),
    .is_div (is_div_op),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .step   (state_q == ST_RUN),
    .prod   (prod),
    .quot   (quot),
    .rem    (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      pneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isdiv_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (!is_md) begin
              if (op_code == OP_MTHI) hi_q <= op_a;
              else                    lo_q <= op_a;
            end else if (is_div_op && b_zero) begin
              done_q <= 1'b1;
              div0_q <= 1'b1;
            end else begin
              pneg_q  <= sgn_op & (op_a[XLEN-1] ^ op_b[XLEN-1]);
              rneg_q  <= sgn_op & op_a[XLEN-1];
              isdiv_q <= is_div_op;
              cnt_q   <= 5'd31;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush)               state_q <= ST_IDLE;
          else if (cnt_q == 5'd0)  state_q <= ST_FIN;
          else                     cnt_q   <= cnt_q - 5'd1;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          if (!flush) begin
            if (isdiv_q) begin
              lo_q <= quot_fix;
              hi_q <= rem_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign stall    = busy & (op_valid | hilo_rd);
  assign done     = done_q;
  assign div0     = div0_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: a reference model pushes expected
// HI/LO/div0 at issue time, and a done monitor pops and compares.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        hilo_rd = 1'b0;
  logic        op_ready, busy, stall, done, div0;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv_ctrl #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .hilo_rd  (hilo_rd),
    .op_ready (op_ready),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div0     (div0),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got done=1 hi=%h lo=%h, want no done", hi_out, lo_out);
      end else begin
        e = sb.pop_front();
        if (hi_out !== e.hi || lo_out !== e.lo || div0 !== e.dz) begin
          n_fail++;
          $display("FAIL result: got hi=%h lo=%h div0=%b, want hi=%h lo=%h div0=%b",
                   hi_out, lo_out, div0, e.hi, e.lo, e.dz);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    logic        dz;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    dz  = 1'b0;
    case (code)
      3'b000: begin p = sa * sbv; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'b001: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'b010: if (b == 0) dz = 1'b1;
              else begin q = sa / sbv; r = sa % sbv; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: if (b == 0) dz = 1'b1;
               else begin m_lo = a / b; m_hi = a % b; end
    endcase
    sb.push_back('{m_hi, m_lo, dz});
  endtask

  task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Entered at the first negedge after the accepting edge.
  task automatic wait_done(output int lat, output int bn);
    lat = 1; bn = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bn++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_md(input string name, input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    int lat, bn;
    push_exp(code, a, b);
    issue(code, a, b);
    wait_done(lat, bn);
    n_tests++;
    if (lat !== 34 || bn !== 33 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timing: got done_cycle=%0d busy_cycles=%0d op_ready=%b, want 34 33 1",
               name, lat, bn, op_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (hi_out !== 0 || lo_out !== 0 || busy !== 0 || op_ready !== 1 || done !== 0 || div0 !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b rdy=%b done=%b div0=%b, want 0 0 0 1 0 0",
               hi_out, lo_out, busy, op_ready, done, div0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 0 || op_ready !== 1 || stall !== 0) begin
      n_fail++;
      $display("FAIL post_reset: got busy=%b rdy=%b stall=%b, want 0 1 0", busy, op_ready, stall);
    end
  endtask

  task automatic test_mult();
    run_md("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7);
    run_md("mult_min",  3'b000, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div();
    run_md("div_neg",  3'b010, 32'hFFFF_FFF9, 32'd2);
    run_md("divu",     3'b011, 32'd7, 32'd2);
    run_md("div_wrap", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div_mix",  3'b010, 32'd100, 32'hFFFF_FFF9);
  endtask

  task automatic test_back_to_back();
    run_md("b2b_first",  3'b001, 32'd12345, 32'd678);
    run_md("b2b_second", 3'b011, 32'hDEAD_BEEF, 32'd13);
  endtask

  task automatic test_div0();
    push_exp(3'b011, 32'd5, 32'd0);
    issue(3'b011, 32'd5, 32'd0);
    n_tests++;
    if (done !== 1'b1 || div0 !== 1'b1 || busy !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      n_fail++;
      $display("FAIL div0_pulse: got done=%b div0=%b busy=%b hi=%h lo=%h, want 1 1 0 %h %h",
               done, div0, busy, hi_out, lo_out, m_hi, m_lo);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || div0 !== 1'b0) begin
      n_fail++;
      $display("FAIL div0_width: got done=%b div0=%b, want 0 0", done, div0);
    end
  endtask

  task automatic test_mthi_mtlo();
    op_valid = 1'b1; op_code = 3'b100; op_a = 32'h1234; op_b = '0;
    @(negedge clk);
    m_hi = 32'h1234;
    n_tests++;
    if (hi_out !== 32'h1234 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: got hi=%h busy=%b, want 00001234 0", hi_out, busy);
    end
    op_code = 3'b101; op_a = 32'hABCD;
    @(negedge clk);
    op_valid = 1'b0;
    m_lo = 32'hABCD;
    n_tests++;
    if (lo_out !== 32'hABCD || hi_out !== 32'h1234) begin
      n_fail++;
      $display("FAIL mtlo: got hi=%h lo=%h, want 00001234 0000abcd", hi_out, lo_out);
    end
  endtask

  task automatic test_hold();
    int cyc, lat, bn;
    push_exp(3'b001, 32'd100, 32'd200);
    issue(3'b001, 32'd100, 32'd200);
    op_valid = 1'b1; op_code = 3'b000; op_a = 32'hFFFF_FFFB; op_b = 32'd6;
    @(negedge clk);
    n_tests++;
    if (op_ready !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_stall: got op_ready=%b stall=%b, want 0 1", op_ready, stall);
    end
    cyc = 0;
    while (op_ready !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc !== 32) begin
      n_fail++;
      $display("FAIL hold_release: got ready after %0d cycles, want 32", cyc);
    end
    push_exp(3'b000, 32'hFFFF_FFFB, 32'd6);
    @(negedge clk);
    op_valid = 1'b0;
    wait_done(lat, bn);
    n_tests++;
    if (lat !== 34 || bn !== 33) begin
      n_fail++;
      $display("FAIL hold_timing: got done_cycle=%0d busy_cycles=%0d, want 34 33", lat, bn);
    end
    hilo_rd = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      n_fail++;
      $display("FAIL hilo_rd_after: got stall=%b hi=%h lo=%h, want 0 %h %h", stall, hi_out, lo_out, m_hi, m_lo);
    end
    hilo_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int seen;
    issue(3'b011, 32'd1000, 32'd7);
    hilo_rd = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hilo_rd: got stall=%b, want 1", stall);
    end
    hilo_rd = 1'b0;
    repeat (21) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      n_fail++;
      $display("FAIL flush_run: got busy=%b hi=%h lo=%h, want 0 %h %h", busy, hi_out, lo_out, m_hi, m_lo);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flush_no_done: got %0d done pulses, want 0", seen);
    end
    flush = 1'b1;
    issue(3'b101, 32'h55, 32'd0);
    flush = 1'b0;
    m_lo = 32'h55;
    n_tests++;
    if (lo_out !== 32'h55 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_accept: got lo=%h busy=%b, want 00000055 0", lo_out, busy);
    end
  endtask

  task automatic test_illegal();
    issue(3'b110, 32'hFFFF_0000, 32'd3);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      n_fail++;
      $display("FAIL illegal_op: got busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
               busy, done, hi_out, lo_out, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid();
    issue(3'b000, 32'd77, 32'd99);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    n_tests++;
    if (hi_out !== 0 || lo_out !== 0 || busy !== 1'b0 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b rdy=%b, want 0 0 0 1", hi_out, lo_out, busy, op_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_div0();
    test_mthi_mtlo();
    test_hold();
    test_flush();
    test_illegal();
    test_reset_mid();
    run_md("after_reset", 3'b011, 32'd9, 32'd4);
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending results, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
